// File: rtl/ann_pkg.sv
// Shared ANN datapath types: weight word format and weight-stream FSM states.
package ann_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 28;

    typedef logic signed [DATA_W_DEF-1:0] weight_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } ws_state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry output buffer between the weight RAM read port and the MAC handshake.
module weight_skid_fifo #(
    parameter int W = 17
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/weight_stream_bram.sv
// Per-neuron weight store: block RAM, host rewrite port, and a
// valid/ready burst streamer with wrap-around addressing.
module weight_stream_bram
    import ann_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = addr_w(DEPTH),
    parameter     INIT_FILE = "weight_0_0.txt"
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_WE,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_ERR,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W:0]   LEN,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic [DATA_W-1:0] W_DATA,
    output logic              W_LAST,
    output logic              BUSY
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L     = (ADDR_W + 1)'(1);

    (* ram_style = "block" *)
    logic [DATA_W-1:0] r_ram [DEPTH];

    ws_state_t         r_state;
    ws_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_len;
    logic              r_rd_vld;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_ld_err;

    logic              w_busy;
    logic              w_start_ok;
    logic              w_wr_ok;
    logic              w_issue;
    logic              w_pop;
    logic              w_fifo_valid;
    logic [DATA_W:0]   w_fifo_dout;
    logic [1:0]        w_fifo_cnt;
    logic [2:0]        w_occ;
    logic [ADDR_W:0]   w_issued_inc;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_busy       = (r_state == S_STREAM);
    assign w_start_ok   = START && (LEN != '0) && (LEN <= LEN_MAX)
                          && (BASE <= LAST_ADDR);
    assign w_wr_ok      = LD_WE && !w_busy && (LD_ADDR <= LAST_ADDR);
    assign w_pop        = w_fifo_valid && W_READY;
    assign w_issued_inc = r_issued + ONE_L;
    assign w_addr_nxt   = (r_rd_addr == LAST_ADDR) ? '0
                          : r_rd_addr + ADDR_W'(1);

    // Words buffered or in flight after this edge; a new read lands one
    // cycle later, so it needs that count to leave a free slot.
    assign w_occ   = {1'b0, w_fifo_cnt} + {2'b0, r_rd_vld} - {2'b0, w_pop};
    assign w_issue = w_busy && (r_issued != r_len) && (w_occ <= 3'd1);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_pop && w_fifo_dout[DATA_W]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_issued  <= '0;
            r_len     <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_ld_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_err  <= LD_WE && !w_wr_ok;
            r_rd_vld  <= w_issue;
            r_rd_last <= w_issue && (w_issued_inc == r_len);
            if (!w_busy && w_start_ok) begin
                r_rd_addr <= BASE;
                r_issued  <= '0;
                r_len     <= LEN;
            end else if (w_issue) begin
                r_rd_addr <= w_addr_nxt;
                r_issued  <= w_issued_inc;
            end
        end
    end

    // RAM array and read register carry no reset so they map onto block RAM.
    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_ram[LD_ADDR] <= LD_DATA;
        end
        if (w_issue) begin
            r_rd_data <= r_ram[r_rd_addr];
        end
    end

    weight_skid_fifo #(
        .W (DATA_W + 1)
    ) u_skid (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (r_rd_vld),
        .i_din   ({r_rd_last, r_rd_data}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_cnt)
    );

    assign W_VALID = w_fifo_valid;
    assign W_DATA  = w_fifo_dout[DATA_W-1:0];
    assign W_LAST  = w_fifo_valid && w_fifo_dout[DATA_W];
    assign BUSY    = w_busy;
    assign LD_ERR  = r_ld_err;

endmodule

// File: tb/tb_weight_stream_bram.sv
// Directed bench for weight_stream_bram: preload, bursts, wrap, backpressure,
// loader rules, ignored starts and mid-burst reset.
module tb_weight_stream_bram;

    localparam int DW  = 16;
    localparam int DEP = 28;
    localparam int AW  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_err;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          w_last;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    int            first_lat;
    int            gaps;
    int            unstable;
    bit            tmo;

    always #5 clk = ~clk;

    weight_stream_bram #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .ADDR_W    (AW),
        .INIT_FILE ("")
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .LD_WE   (ld_we),
        .LD_ADDR (ld_addr),
        .LD_DATA (ld_data),
        .LD_ERR  (ld_err),
        .START   (start),
        .BASE    (base),
        .LEN     (len),
        .W_VALID (w_valid),
        .W_READY (w_ready),
        .W_DATA  (w_data),
        .W_LAST  (w_last),
        .BUSY    (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int c);
        return (mode == 0) ? 1'b1 : ((c % 3) == 0);
    endfunction

    // Starts a burst and collects accepted words. c counts cycles after
    // the edge that samples START.
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l,
                             input int mode, input bit inj);
        bit            done;
        bit            stalled;
        bit            got;
        logic [DW-1:0] hd;
        logic          hl;
        q_data.delete();
        q_last.delete();
        first_lat = -1;
        gaps      = 0;
        unstable  = 0;
        done      = 0;
        stalled   = 0;
        got       = 0;
        hd        = '0;
        hl        = 1'b0;
        start     = 1'b1;
        base      = b;
        len       = l;
        w_ready   = rdy(mode, 0);
        tick();
        start = 1'b0;
        ld_we = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            w_ready = rdy(mode, c);
            start   = inj && (c == 1);
            if (inj && c == 1) begin
                base = '0;
                len  = 6'd5;
            end
            if (stalled && (!w_valid || w_data !== hd || w_last !== hl))
                unstable++;
            stalled = 0;
            if (w_valid) begin
                if (!got) first_lat = c;
                got = 1;
                if (w_ready) begin
                    q_data.push_back(w_data);
                    q_last.push_back(w_last);
                    if (w_last) done = 1;
                end else begin
                    stalled = 1;
                    hd      = w_data;
                    hl      = w_last;
                end
            end else if (got) begin
                gaps++;
            end
            tick();
        end
        start = 1'b0;
        tmo   = !done;
        n_chk++;
        if (tmo) begin
            n_fail++;
            $display("FAIL burst_timeout base=%0d len=%0d got=%0d words", b, l, q_data.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_we = 0; ld_addr = '0; ld_data = '0;
        start = 0; base = '0; len = '0; w_ready = 0;
        tick();
        tick();
        n_chk++;
        if ({w_valid, w_last, busy, ld_err} !== 4'b0 || w_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b l=%b b=%b e=%b d=%h want all 0",
                     w_valid, w_last, busy, ld_err, w_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEP; i++) begin
            ld_we = 1; ld_addr = AW'(i); ld_data = DW'(100 + i);
            tick();
            n_chk++;
            if (ld_err !== 1'b0) begin
                n_fail++;
                $display("FAIL preload_err addr=%0d got %b want 0", i, ld_err);
            end
        end
        ld_we = 0;
        tick();
    endtask

    task automatic test_full_burst();
        run_burst(5'd0, 6'd28, 0, 0);
        n_chk++;
        if (q_data.size() != 28) begin
            n_fail++;
            $display("FAIL full_count got %0d want 28", q_data.size());
        end
        for (int i = 0; i < q_data.size(); i++) begin
            n_chk++;
            if (q_data[i] !== DW'(100 + i) || q_last[i] !== (i == 27)) begin
                n_fail++;
                $display("FAIL full_word[%0d] got %0d/%b want %0d/%b",
                         i, q_data[i], q_last[i], 100 + i, i == 27);
            end
        end
        n_chk++;
        if (first_lat != 2 || gaps != 0) begin
            n_fail++;
            $display("FAIL full_timing got lat=%0d gaps=%0d want lat=2 gaps=0", first_lat, gaps);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_busy_after got %b want 0", busy);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp [4];
        exp = '{16'd126, 16'd127, 16'd100, 16'd101};
        run_burst(5'd26, 6'd4, 0, 0);
        n_chk++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_count got %0d want 4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_chk++;
            if (q_data[i] !== exp[i] || q_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_word[%0d] got %0d/%b want %0d/%b",
                         i, q_data[i], q_last[i], exp[i], i == 3);
            end
        end
        n_chk++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle got busy=%b valid=%b want 0/0", busy, w_valid);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        run_burst(5'd0, 6'd28, 1, 0);
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== DW'(100 + i)) bad++;
        n_chk++;
        if (q_data.size() != 28 || bad != 0) begin
            n_fail++;
            $display("FAIL bp_data got n=%0d bad=%0d want n=28 bad=0", q_data.size(), bad);
        end
        n_chk++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL bp_stable got %0d changes while stalled want 0", unstable);
        end
    endtask

    task automatic test_loader();
        ld_we = 1; ld_addr = 5'd5; ld_data = 16'hBEEF;
        tick();
        ld_we = 0;
        n_chk++;
        if (ld_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_idle_err got %b want 0", ld_err);
        end
        run_burst(5'd4, 6'd3, 0, 0);
        n_chk++;
        if (q_data.size() != 3 || q_data[0] !== 16'd104 || q_data[1] !== 16'hBEEF
            || q_data[2] !== 16'd106) begin
            n_fail++;
            $display("FAIL ld_readback got n=%0d %h want 0068 BEEF 006a", q_data.size(),
                     q_data.size() > 1 ? q_data[1] : 16'hxxxx);
        end
        start = 1; base = 5'd6; len = 6'd1; w_ready = 0;
        tick();
        start = 0;
        ld_we = 1; ld_addr = 5'd6; ld_data = 16'h1234;
        tick();
        ld_we = 0;
        n_chk++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_busy_err got %b want 1", ld_err);
        end
        tick();
        n_chk++;
        if (ld_err !== 1'b0 || w_valid !== 1'b1 || w_data !== 16'd106 || w_last !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_busy_nowrite got err=%b v=%b d=%h l=%b want 0/1/006a/1",
                     ld_err, w_valid, w_data, w_last);
        end
        w_ready = 1;
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_busy_done got %b want 0", busy);
        end
        ld_we = 1; ld_addr = 5'd28; ld_data = 16'hDEAD;
        tick();
        ld_we = 0;
        n_chk++;
        if (ld_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_range_err got %b want 1", ld_err);
        end
        ld_we = 1; ld_addr = 5'd7; ld_data = 16'h0777;
        run_burst(5'd7, 6'd1, 0, 0);
        n_chk++;
        if (q_data.size() != 1 || q_data[0] !== 16'h0777) begin
            n_fail++;
            $display("FAIL ld_same_cycle got n=%0d d=%h want 1/0777", q_data.size(),
                     q_data.size() > 0 ? q_data[0] : 16'hxxxx);
        end
    endtask

    task automatic test_ignored_start();
        logic [AW:0]   lens [3];
        logic [AW-1:0] bases [3];
        int            seen;
        lens  = '{6'd0, 6'd29, 6'd1};
        bases = '{5'd0, 5'd0, 5'd28};
        for (int k = 0; k < 3; k++) begin
            start = 1; base = bases[k]; len = lens[k]; w_ready = 1;
            tick();
            start = 0;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                if (w_valid || busy) seen++;
                tick();
            end
            n_chk++;
            if (seen != 0) begin
                n_fail++;
                $display("FAIL ign_start[%0d] base=%0d len=%0d got %0d active cycles want 0",
                         k, bases[k], lens[k], seen);
            end
        end
        run_burst(5'd10, 6'd3, 1, 1);
        n_chk++;
        if (q_data.size() != 3 || q_data[0] !== 16'd110 || q_data[2] !== 16'd112
            || q_last[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_busy_start got n=%0d first=%0d want 3 words 110..112",
                     q_data.size(), q_data.size() > 0 ? q_data[0] : 16'hxxxx);
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (w_valid || busy) seen++;
            tick();
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL ign_busy_after got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit hit;
        start = 1; base = 5'd0; len = 6'd28; w_ready = 1;
        tick();
        start = 0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (w_valid && w_data == 16'd102) hit = 1;
            else tick();
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rst_third_word got none want 102 within 20 cycles");
        end
        rst = 1;
        #1;
        n_chk++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || w_data !== '0 || w_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async got v=%b b=%b d=%h l=%b want 0/0/0000/0",
                     w_valid, busy, w_data, w_last);
        end
        tick();
        rst = 0;
        tick();
        run_burst(5'd20, 6'd5, 0, 0);
        n_chk++;
        if (q_data.size() != 5 || q_data[0] !== 16'd120 || q_data[4] !== 16'd124
            || first_lat != 2) begin
            n_fail++;
            $display("FAIL rst_new_burst got n=%0d first=%0d lat=%0d want 5/120/2",
                     q_data.size(), q_data.size() > 0 ? q_data[0] : 16'hxxxx, first_lat);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_full_burst();
        test_wrap();
        test_backpressure();
        test_loader();
        test_ignored_start();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
